vm_change_dispenser: RTL and testbench

Change-dispensing scheduler for the vending machine. It is started with a change amount in cents and keeps a per-denomination inventory. A greedy dry-run plans the change against that inventory; if the plan cannot be met it rejects the request atomically. If the plan is met it issues one denomination code per valid/ready handshake to the coin/note ejector and decrements the inventory. It sits between the vending machine's change-computation logic and the change-output port (`o_change_denomination_code` / `o_change_valid` / `o_no_change`).

---
 rtl/vm_change_dispenser.sv | 217 +++++++++++++++++++++
 tb/tb_vm_change_dispenser.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser
// Change-dispensing scheduler for the vending machine. A request carries a
// change amount in cents. A greedy dry-run (highest value first, no
// backtracking) plans the change against a per-denomination inventory. If the
// plan cannot cover the amount, the request is rejected and the inventory is
// left untouched. If it can, the planned pieces are issued one denomination
// code per valid/ready handshake, and the inventory is decremented as each
// piece is accepted.
//
// Ports:
//   i_clk                      clock, all logic on the rising edge
//   i_rst_n                    synchronous active-low reset
//   i_change_amount            change to give in cents, taken on an accepted start
//   i_change_start             request strobe, accepted only while o_ready
//   o_ready                    high while idle
//   o_change_denomination_code denomination code being ejected (0 = 500.00 .. 14 = 0.01)
//   o_change_valid             code valid towards the ejector
//   i_change_ready             ejector accepts the code
//   o_done                     one-cycle pulse at the end of every request
//   o_no_change                one-cycle pulse together with o_done on a rejected request
//   i_refill                   inventory refill strobe, honoured only while idle
//   i_refill_code              denomination to refill (15 is ignored)
//   i_refill_count             pieces added, saturating at the counter maximum
module vm_change_dispenser #(
  parameter int AMOUNT_W                = 17,
  parameter int CNT_W                   = 8,
  parameter int DENOMINATION_AMOUNT_500 = 8,
  parameter int DENOMINATION_AMOUNT_200 = 8,
  parameter int DENOMINATION_AMOUNT_100 = 8,
  parameter int DENOMINATION_AMOUNT_50  = 8,
  parameter int DENOMINATION_AMOUNT_20  = 8,
  parameter int DENOMINATION_AMOUNT_10  = 8,
  parameter int DENOMINATION_AMOUNT_5   = 8,
  parameter int DENOMINATION_AMOUNT_2   = 8,
  parameter int DENOMINATION_AMOUNT_1   = 8,
  parameter int DENOMINATION_AMOUNT0_50 = 8,
  parameter int DENOMINATION_AMOUNT0_25 = 8,
  parameter int DENOMINATION_AMOUNT0_10 = 8,
  parameter int DENOMINATION_AMOUNT0_05 = 8,
  parameter int DENOMINATION_AMOUNT0_02 = 8,
  parameter int DENOMINATION_AMOUNT0_01 = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [AMOUNT_W-1:0] i_change_amount,
  input  logic                i_change_start,
  output logic                o_ready,
  output logic [3:0]          o_change_denomination_code,
  output logic                o_change_valid,
  input  logic                i_change_ready,
  output logic                o_done,
  output logic                o_no_change,
  input  logic                i_refill,
  input  logic [3:0]          i_refill_code,
  input  logic [CNT_W-1:0]    i_refill_count
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    DISPENSE,
    DONE,
    FAIL
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    inv_q  [15];
  logic [CNT_W-1:0]    plan_q [15];
  logic [AMOUNT_W-1:0] rem_q;
  logic [3:0]          den_q;

  // Value in cents of each denomination code.
  function automatic logic [31:0] denomValue(input logic [3:0] code);
    case (code)
      4'd0:    denomValue = 32'd50000;
      4'd1:    denomValue = 32'd20000;
      4'd2:    denomValue = 32'd10000;
      4'd3:    denomValue = 32'd5000;
      4'd4:    denomValue = 32'd2000;
      4'd5:    denomValue = 32'd1000;
      4'd6:    denomValue = 32'd500;
      4'd7:    denomValue = 32'd200;
      4'd8:    denomValue = 32'd100;
      4'd9:    denomValue = 32'd50;
      4'd10:   denomValue = 32'd25;
      4'd11:   denomValue = 32'd10;
      4'd12:   denomValue = 32'd5;
      4'd13:   denomValue = 32'd2;
      4'd14:   denomValue = 32'd1;
      default: denomValue = 32'd0;
    endcase
  endfunction

  // Inventory loaded by reset, one parameter per denomination.
  function automatic logic [CNT_W-1:0] resetInv(input int idx);
    case (idx)
      0:       resetInv = CNT_W'(DENOMINATION_AMOUNT_500);
      1:       resetInv = CNT_W'(DENOMINATION_AMOUNT_200);
      2:       resetInv = CNT_W'(DENOMINATION_AMOUNT_100);
      3:       resetInv = CNT_W'(DENOMINATION_AMOUNT_50);
      4:       resetInv = CNT_W'(DENOMINATION_AMOUNT_20);
      5:       resetInv = CNT_W'(DENOMINATION_AMOUNT_10);
      6:       resetInv = CNT_W'(DENOMINATION_AMOUNT_5);
      7:       resetInv = CNT_W'(DENOMINATION_AMOUNT_2);
      8:       resetInv = CNT_W'(DENOMINATION_AMOUNT_1);
      9:       resetInv = CNT_W'(DENOMINATION_AMOUNT0_50);
      10:      resetInv = CNT_W'(DENOMINATION_AMOUNT0_25);
      11:      resetInv = CNT_W'(DENOMINATION_AMOUNT0_10);
      12:      resetInv = CNT_W'(DENOMINATION_AMOUNT0_05);
      13:      resetInv = CNT_W'(DENOMINATION_AMOUNT0_02);
      14:      resetInv = CNT_W'(DENOMINATION_AMOUNT0_01);
      default: resetInv = '0;
    endcase
  endfunction

  // Plan scan: lowest code with pieces left is the one presented to the
  // ejector; the count of non-empty entries tells whether the current
  // handshake takes the very last planned piece.
  logic [3:0]       codeSel;
  logic [3:0]       nzCnt;
  logic             planAny;
  logic             lastPiece;
  logic             handshake;

  always_comb begin
    codeSel = 4'd0;
    nzCnt   = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (plan_q[i] != '0) begin
        codeSel = 4'(i);
        nzCnt   = nzCnt + 4'd1;
      end
    end
    planAny   = (nzCnt != 4'd0);
    lastPiece = (plan_q[codeSel] == CNT_W'(1)) && (nzCnt == 4'd1);
  end

  assign o_ready                    = (state_q == IDLE);
  assign o_change_valid             = (state_q == DISPENSE) && planAny;
  assign o_change_denomination_code = codeSel;
  assign o_done                     = (state_q == DONE) || (state_q == FAIL);
  assign o_no_change                = (state_q == FAIL);
  assign handshake                  = o_change_valid && i_change_ready;

  // Greedy step for the denomination currently under consideration.
  logic [31:0] curVal;
  logic        canTake;

  always_comb begin
    curVal  = denomValue(den_q);
    canTake = (32'(rem_q) >= curVal) && (plan_q[den_q] < inv_q[den_q]);
  end

  // Saturating refill sum; the extra top bit catches the overflow.
  logic [CNT_W:0]   refillSum;
  logic [CNT_W-1:0] refillSat;

  always_comb begin
    refillSum = {1'b0, inv_q[i_refill_code]} + {1'b0, i_refill_count};
    refillSat = refillSum[CNT_W] ? '1 : refillSum[CNT_W-1:0];
  end

  // Main FSM. A refill in the same idle cycle as a start lands before CALC
  // begins, so the dry-run sees the refilled inventory.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      den_q   <= 4'd0;
      for (int i = 0; i < 15; i++) begin
        inv_q[i]  <= resetInv(i);
        plan_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (i_refill && (i_refill_code <= 4'd14)) begin
            inv_q[i_refill_code] <= refillSat;
          end
          if (i_change_start) begin
            rem_q <= i_change_amount;
            den_q <= 4'd0;
            for (int i = 0; i < 15; i++) begin
              plan_q[i] <= '0;
            end
            state_q <= (i_change_amount == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          if (rem_q == '0) begin
            state_q <= DISPENSE;
          end else if (canTake) begin
            rem_q         <= rem_q - AMOUNT_W'(curVal);
            plan_q[den_q] <= plan_q[den_q] + CNT_W'(1);
          end else if (den_q == 4'd14) begin
            state_q <= FAIL;
          end else begin
            den_q <= den_q + 4'd1;
          end
        end
        DISPENSE: begin
          if (handshake) begin
            plan_q[codeSel] <= plan_q[codeSel] - CNT_W'(1);
            inv_q[codeSel]  <= inv_q[codeSel] - CNT_W'(1);
            if (lastPiece) begin
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        FAIL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb_vm_change_dispenser
// Self-checking bench for vm_change_dispenser. Expected denomination codes are
// queued when a request is driven and compared by a scoreboard process at every
// handshake; the scoreboard also keeps an inventory model. Each scenario task
// checks timing, pulses and inventory inline.
module tb_vm_change_dispenser;

  localparam int AMOUNT_W = 17;
  localparam int CNT_W    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstN;
  logic [AMOUNT_W-1:0] changeAmount;
  logic                changeStart;
  logic                changeReady;
  logic                refill;
  logic [3:0]          refillCode;
  logic [CNT_W-1:0]    refillCount;
  logic                ready, valid, done, noChg;
  logic [3:0]          code;

  logic [AMOUNT_W-1:0] changeAmount2;
  logic                changeStart2;
  logic                ready2, valid2, done2, noChg2;
  logic [3:0]          code2;

  vm_change_dispenser #(.AMOUNT_W(AMOUNT_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_change_amount(changeAmount), .i_change_start(changeStart),
    .o_ready(ready), .o_change_denomination_code(code), .o_change_valid(valid),
    .i_change_ready(changeReady), .o_done(done), .o_no_change(noChg),
    .i_refill(refill), .i_refill_code(refillCode), .i_refill_count(refillCount)
  );

  vm_change_dispenser #(.AMOUNT_W(AMOUNT_W), .CNT_W(CNT_W),
                        .DENOMINATION_AMOUNT0_02(1), .DENOMINATION_AMOUNT0_01(0)) dut2 (
    .i_clk(clk), .i_rst_n(rstN),
    .i_change_amount(changeAmount2), .i_change_start(changeStart2),
    .o_ready(ready2), .o_change_denomination_code(code2), .o_change_valid(valid2),
    .i_change_ready(1'b1), .o_done(done2), .o_no_change(noChg2),
    .i_refill(1'b0), .i_refill_code(4'd0), .i_refill_count('0)
  );

  int total = 0;
  int bad   = 0;

  int expQ[$];
  int expInv[15];

  int firstValid, doneAt, validCycles, heldCount, heldInvSnap;
  bit noChgSeen, timedOut;
  int hsCycles[$];
  int heldCodes[$];

  // Scoreboard: every handshake pops the next expected code and updates the
  // inventory model with the expected denomination.
  always @(negedge clk) begin
    int e;
    if (rstN && valid && changeReady) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_unexpected: got code %0d, no handshake expected", code);
      end else begin
        e = expQ.pop_front();
        if (int'(code) !== e) begin
          bad++;
          $display("[TB] FAIL sb_code: got %0d want %0d", code, e);
        end
        expInv[e] = expInv[e] - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on dut and records what happened until o_done.
  // With hold>0 the ejector stalls for that many valid cycles first.
  task automatic runRequest(input int amount, input int hold);
    int k;
    firstValid = -1; doneAt = -1; validCycles = 0; heldCount = 0;
    noChgSeen = 0; timedOut = 0; heldInvSnap = -1;
    hsCycles.delete(); heldCodes.delete();
    tick();
    changeAmount = AMOUNT_W'(amount);
    changeStart  = 1'b1;
    changeReady  = (hold == 0);
    tick();
    changeStart = 1'b0;
    k = 1;
    while (doneAt < 0 && k <= 200) begin
      @(negedge clk);
      if (noChg) noChgSeen = 1;
      if (valid) begin
        if (firstValid < 0) firstValid = k;
        validCycles++;
        if (changeReady) hsCycles.push_back(k);
        else begin
          heldCount++;
          heldCodes.push_back(int'(code));
          heldInvSnap = int'(dut.inv_q[code]);
        end
      end
      if (done) doneAt = k;
      else begin
        tick();
        k++;
        if (!changeReady && heldCount >= hold) changeReady = 1'b1;
      end
    end
    if (doneAt < 0) timedOut = 1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; changeStart = 1'b0; changeStart2 = 1'b0; changeReady = 1'b1;
    changeAmount = '0; changeAmount2 = '0;
    refill = 1'b0; refillCode = 4'd0; refillCount = '0;
    for (int i = 0; i < 15; i++) expInv[i] = 8;
    tick(); tick();
    rstN = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", ready); end
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
    total++; if (done !== 1'b0 || noChg !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulses: got done=%b nochg=%b want 0 0", done, noChg); end
    total++; if (code !== 4'd0) begin bad++; $display("[TB] FAIL reset_code: got %0d want 0", code); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (int'(dut.inv_q[i]) !== expInv[i]) begin bad++; $display("[TB] FAIL reset_inv%0d: got %0d want %0d", i, dut.inv_q[i], expInv[i]); end
    end
  endtask

  task automatic test_single_100();
    expQ.push_back(8);
    runRequest(100, 0);
    total++; if (timedOut) begin bad++; $display("[TB] FAIL r100_timeout: got no done want done"); end
    total++; if (firstValid !== 11) begin bad++; $display("[TB] FAIL r100_first_valid: got %0d want 11", firstValid); end
    total++; if (validCycles !== 1) begin bad++; $display("[TB] FAIL r100_valid_cycles: got %0d want 1", validCycles); end
    total++; if (doneAt !== 12) begin bad++; $display("[TB] FAIL r100_done_at: got %0d want 12", doneAt); end
    total++; if (noChgSeen !== 1'b0) begin bad++; $display("[TB] FAIL r100_nochg: got 1 want 0"); end
    total++; if (int'(dut.inv_q[8]) !== expInv[8] || expInv[8] !== 7) begin bad++; $display("[TB] FAIL r100_inv8: got %0d want 7", dut.inv_q[8]); end
    tick();
    @(negedge clk);
    total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL r100_ready_after: got ready=%b done=%b want 1 0", ready, done); end
  endtask

  task automatic test_seq_388();
    int exp388[7] = '{7, 8, 9, 10, 11, 13, 14};
    bit consecutive;
    foreach (exp388[i]) expQ.push_back(exp388[i]);
    runRequest(388, 0);
    consecutive = (hsCycles.size() == 7);
    for (int i = 1; i < hsCycles.size(); i++) if (hsCycles[i] != hsCycles[0] + i) consecutive = 0;
    total++; if (timedOut) begin bad++; $display("[TB] FAIL r388_timeout: got no done want done"); end
    total++; if (!consecutive) begin bad++; $display("[TB] FAIL r388_consecutive: got %0d handshakes not back-to-back want 7 consecutive", hsCycles.size()); end
    total++; if (hsCycles.size() == 7 && doneAt !== hsCycles[6] + 1) begin bad++; $display("[TB] FAIL r388_done_at: got %0d want %0d", doneAt, hsCycles[6] + 1); end
    total++; if (noChgSeen !== 1'b0) begin bad++; $display("[TB] FAIL r388_nochg: got 1 want 0"); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (int'(dut.inv_q[i]) !== expInv[i]) begin bad++; $display("[TB] FAIL r388_inv%0d: got %0d want %0d", i, dut.inv_q[i], expInv[i]); end
    end
  endtask

  task automatic test_backpressure_300();
    int preInv7;
    bit allSeven;
    preInv7 = expInv[7];
    expQ.push_back(7);
    expQ.push_back(8);
    runRequest(300, 5);
    allSeven = (heldCodes.size() == 5);
    foreach (heldCodes[i]) if (heldCodes[i] != 7) allSeven = 0;
    total++; if (timedOut) begin bad++; $display("[TB] FAIL bp_timeout: got no done want done"); end
    total++; if (!allSeven) begin bad++; $display("[TB] FAIL bp_held_code: got %0d held cycles not all code 7 want 5 of code 7", heldCodes.size()); end
    total++; if (heldInvSnap !== preInv7) begin bad++; $display("[TB] FAIL bp_held_inv: got %0d want %0d", heldInvSnap, preInv7); end
    total++; if (hsCycles.size() !== 2 || hsCycles[1] !== hsCycles[0] + 1 || hsCycles[0] !== firstValid + 5) begin
      bad++; $display("[TB] FAIL bp_handshakes: got %0d handshakes first at %0d want 2 consecutive at %0d", hsCycles.size(), (hsCycles.size() > 0) ? hsCycles[0] : -1, firstValid + 5);
    end
    total++; if (int'(dut.inv_q[7]) !== expInv[7] || int'(dut.inv_q[8]) !== expInv[8]) begin
      bad++; $display("[TB] FAIL bp_inv: got %0d/%0d want %0d/%0d", dut.inv_q[7], dut.inv_q[8], expInv[7], expInv[8]);
    end
  endtask

  task automatic test_zero_amount();
    runRequest(0, 0);
    total++; if (doneAt !== 1) begin bad++; $display("[TB] FAIL zero_done_at: got %0d want 1", doneAt); end
    total++; if (validCycles !== 0 || noChgSeen !== 1'b0) begin bad++; $display("[TB] FAIL zero_outputs: got valid=%0d nochg=%b want 0 0", validCycles, noChgSeen); end
  endtask

  task automatic test_refill();
    int k;
    bit seen;
    tick();
    refill = 1'b1; refillCode = 4'd14; refillCount = CNT_W'(250);
    tick();
    refill = 1'b0;
    expInv[14] = (expInv[14] + 250 > 255) ? 255 : expInv[14] + 250;
    @(negedge clk);
    total++; if (int'(dut.inv_q[14]) !== expInv[14] || expInv[14] !== 255) begin bad++; $display("[TB] FAIL refill_sat: got %0d want 255", dut.inv_q[14]); end
    expQ.push_back(8);
    tick();
    changeReady = 1'b0; changeAmount = AMOUNT_W'(100); changeStart = 1'b1;
    tick();
    changeStart = 1'b0;
    seen = 0;
    for (k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (valid) seen = 1; else tick();
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL refill_wait_valid: got no valid want valid"); end
    tick();
    refill = 1'b1; refillCode = 4'd0; refillCount = CNT_W'(5);
    tick();
    refill = 1'b0;
    @(negedge clk);
    total++; if (int'(dut.inv_q[0]) !== expInv[0]) begin bad++; $display("[TB] FAIL refill_busy_ignored: got %0d want %0d", dut.inv_q[0], expInv[0]); end
    total++; if (valid !== 1'b1 || code !== 4'd8) begin bad++; $display("[TB] FAIL refill_busy_hold: got valid=%b code=%0d want 1 8", valid, code); end
    tick();
    changeReady = 1'b1;
    seen = 0;
    for (k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1; else tick();
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL refill_done: got no done want done"); end
  endtask

  task automatic test_fail_nongreedy();
    int k, doneAt2;
    bit sawValid, earlyNc, ncAtDone;
    sawValid = 0; earlyNc = 0; ncAtDone = 0; doneAt2 = -1;
    tick();
    changeAmount2 = AMOUNT_W'(3); changeStart2 = 1'b1;
    tick();
    changeStart2 = 1'b0;
    for (k = 1; k <= 60 && doneAt2 < 0; k++) begin
      @(negedge clk);
      if (valid2) sawValid = 1;
      if (done2) begin doneAt2 = k; ncAtDone = noChg2; end
      else begin
        if (noChg2) earlyNc = 1;
        tick();
      end
    end
    total++; if (doneAt2 < 0) begin bad++; $display("[TB] FAIL fail_timeout: got no done want done"); end
    total++; if (sawValid !== 1'b0) begin bad++; $display("[TB] FAIL fail_no_valid: got valid want none"); end
    total++; if (ncAtDone !== 1'b1 || earlyNc !== 1'b0) begin bad++; $display("[TB] FAIL fail_nochg: got at_done=%b early=%b want 1 0", ncAtDone, earlyNc); end
    total++; if (dut2.inv_q[13] !== CNT_W'(1)) begin bad++; $display("[TB] FAIL fail_inv13: got %0d want 1", dut2.inv_q[13]); end
  endtask

  task automatic test_reset_midrequest();
    int k;
    bit seen;
    tick();
    changeReady = 1'b0; changeAmount = AMOUNT_W'(100); changeStart = 1'b1;
    tick();
    changeStart = 1'b0;
    seen = 0;
    for (k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (valid) seen = 1; else tick();
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL midrst_wait_valid: got no valid want valid"); end
    tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 15; i++) expInv[i] = 8;
    @(negedge clk);
    total++; if (valid !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_outputs: got valid=%b ready=%b done=%b want 0 1 0", valid, ready, done); end
    total++; if (dut.plan_q[8] !== '0) begin bad++; $display("[TB] FAIL midrst_plan: got %0d want 0", dut.plan_q[8]); end
    changeReady = 1'b1;
  endtask

  task automatic test_start_while_busy();
    int k, doneCount;
    expQ.push_back(8);
    doneCount = 0;
    tick();
    changeAmount = AMOUNT_W'(100); changeStart = 1'b1;
    tick();
    changeStart = 1'b0;
    tick(); tick();
    changeAmount = AMOUNT_W'(50); changeStart = 1'b1;
    tick();
    changeStart = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) doneCount++;
      tick();
    end
    total++; if (doneCount !== 1) begin bad++; $display("[TB] FAIL busy_start_dones: got %0d want 1", doneCount); end
    total++; if (int'(dut.inv_q[9]) !== expInv[9] || int'(dut.inv_q[8]) !== expInv[8]) begin
      bad++; $display("[TB] FAIL busy_start_inv: got %0d/%0d want %0d/%0d", dut.inv_q[8], dut.inv_q[9], expInv[8], expInv[9]);
    end
  endtask

  initial begin
    test_reset();
    test_single_100();
    test_seq_388();
    test_backpressure_300();
    test_zero_amount();
    test_refill();
    test_fail_nongreedy();
    test_reset_midrequest();
    test_start_while_busy();
    @(negedge clk);
    total++; if (expQ.size() !== 0) begin bad++; $display("[TB] FAIL sb_leftover: got %0d pending want 0", expQ.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
